// File: rtl/regfile_wb_arbiter.sv
// Two-source writeback arbiter for a register file: the load unit normally wins,
// and the ALU is forced through after STARVE_LIMIT consecutive stalled cycles.
module regfile_wb_arbiter #(
  parameter int STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        wb0_valid,
  input  logic [2:0]  wb0_dest,
  input  logic [15:0] wb0_data,
  output logic        wb0_ready,
  input  logic        wb1_valid,
  input  logic [2:0]  wb1_dest,
  input  logic [15:0] wb1_data,
  output logic        wb1_ready,
  output logic        reg_write_en,
  output logic [2:0]  reg_write_dest,
  output logic [15:0] reg_write_data,
  output logic        grant_id
);

  localparam logic [2:0] LIMIT = 3'(STARVE_LIMIT);

  typedef enum logic {NORMAL, FORCE0} state_t;

  state_t      r_state;
  state_t      w_stateNext;
  logic [2:0]  r_starveCnt;
  logic [2:0]  w_starveNext;
  logic        w_grant0;
  logic        w_grant1;

  // State and starvation count move together; FORCE0 marks a saturated count.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= NORMAL;
      r_starveCnt <= 3'd0;
    end else begin
      r_state     <= w_stateNext;
      r_starveCnt <= w_starveNext;
    end
  end

  always_comb begin
    w_grant0     = 1'b0;
    w_grant1     = 1'b0;
    w_starveNext = 3'd0;
    w_stateNext  = NORMAL;
    if (!rst) begin
      if (wb0_valid && (r_state == FORCE0 || !wb1_valid)) begin
        w_grant0 = 1'b1;
      end else if (wb1_valid) begin
        w_grant1 = 1'b1;
      end
    end
    if (wb0_valid && !w_grant0) begin
      w_starveNext = r_starveCnt + 3'd1;
    end
    if (w_starveNext == LIMIT) begin
      w_stateNext = FORCE0;
    end
  end

  assign wb0_ready = w_grant0;
  assign wb1_ready = w_grant1;

  // Write port is registered; index/data/source hold when no transfer occurs.
  always_ff @(posedge clk) begin
    if (rst) begin
      reg_write_en   <= 1'b0;
      reg_write_dest <= 3'd0;
      reg_write_data <= 16'd0;
      grant_id       <= 1'b0;
    end else if (w_grant1) begin
      reg_write_en   <= 1'b1;
      reg_write_dest <= wb1_dest;
      reg_write_data <= wb1_data;
      grant_id       <= 1'b1;
    end else if (w_grant0) begin
      reg_write_en   <= 1'b1;
      reg_write_dest <= wb0_dest;
      reg_write_data <= wb0_data;
      grant_id       <= 1'b0;
    end else begin
      reg_write_en   <= 1'b0;
    end
  end

endmodule

// File: doc/regfile_wb_arbiter.md
REGFILE_WB_ARBITER -- requirements
Module: regfile_wb_arbiter

Interface
REQ-001 SHALL have parameter: STARVE_LIMIT, default 4, consecutive stalled cycles of requester 0 before it is forced to win; legal range 1..7.
REQ-002 SHALL have one clock and a synchronous, active-high reset.
REQ-003 SHALL have port: clk  input  1  rising-edge clock for all state.
REQ-004 SHALL have port: rst  input  1  synchronous active-high reset.
REQ-005 SHALL have port: wb0_valid  input  1  ALU writeback request.
REQ-006 SHALL have port: wb0_dest  input  3  ALU destination register index.
REQ-007 SHALL have port: wb0_data  input  16  ALU result.
REQ-008 SHALL have port: wb0_ready  output  1  ALU request accepted this cycle.
REQ-009 SHALL have port: wb1_valid  input  1  load-unit writeback request.
REQ-010 SHALL have port: wb1_dest  input  3  load destination register index.
REQ-011 SHALL have port: wb1_data  input  16  load data.
REQ-012 SHALL have port: wb1_ready  output  1  load request accepted this cycle.
REQ-013 SHALL have port: reg_write_en  output  1  register-file write enable, registered.
REQ-014 SHALL have port: reg_write_dest  output  3  register-file write index, registered.
REQ-015 SHALL have port: reg_write_data  output  16  register-file write data, registered.
REQ-016 SHALL have port: grant_id  output  1  source of the current registered write (0 = ALU, 1 = load).

Function
REQ-017 SHALL define transfer N as wbN_valid && wbN_ready on a rising edge; at most one transfer per cycle.
REQ-018 SHALL drive wb0_ready and wb1_ready combinationally from current valids and starvation state; requesters hold valid/dest/data stable until ready.
REQ-019 SHALL use default priority with requester 1 (load) winning when both are valid.
REQ-020 SHALL keep a starvation counter starve_cnt (3 bits): +1 each cycle wb0_valid && !wb0_ready; cleared on a wb0 transfer or when wb0_valid is 0.
REQ-021 SHALL, when starve_cnt == STARVE_LIMIT, grant requester 0 that cycle even if wb1_valid = 1 (state FORCE0); otherwise state is NORMAL.
REQ-022 SHALL set wbN_ready = 0 when wbN_valid = 0, so no ready is asserted without a request.
REQ-023 SHALL, on a transfer at edge k, present reg_write_en = 1, dest, data and grant_id from that edge until edge k+1; the register file commits at edge k+1.
REQ-024 SHALL drop reg_write_en to 0 on any edge with no transfer; reg_write_dest, reg_write_data and grant_id then hold their last values.
REQ-025 SHALL sustain back-to-back transfers, one per cycle, with no bubble.
REQ-026 SHALL not arbitrate on destination: equal dest from both requesters is resolved purely by order, so the later commit wins.
REQ-027 SHALL pass data unmodified, all 16 bits, and any dest 0..7, including register 0.
REQ-028 SHALL never let starve_cnt exceed STARVE_LIMIT: a forced grant clears it.

Reset
REQ-029 SHALL, on an edge with rst = 1, clear reg_write_en, reg_write_dest, reg_write_data, grant_id and starve_cnt to 0 and set state to NORMAL.
REQ-030 SHALL hold wb0_ready = wb1_ready = 0 while rst = 1; requests present during reset are not consumed and are arbitrated from the first edge after rst falls.
REQ-031 SHALL, on a reset asserted mid-stream, discard the write being presented (reg_write_en = 0 after the reset edge), so no partial write occurs.

Verification
REQ-032 SHALL cover single request: wb0 valid, dest 3, data 0x1234, wb1 idle -> wb0_ready = 1 that cycle; next cycle en = 1, dest 3, data 0x1234, grant_id 0; following cycle en = 0.
REQ-033 SHALL cover contention: both valid (wb0 dest 1 data 0xAAAA, wb1 dest 2 data 0x5555) -> wb1 granted first, wb0 granted the next cycle; writes are dest 2 then dest 1 on consecutive cycles.
REQ-034 SHALL cover starvation with STARVE_LIMIT = 4: wb1 valid continuously with a new request each cycle, wb0 valid throughout -> wb0_ready = 1 on the 5th cycle, then wb1 resumes; the pattern repeats every 5 cycles.
REQ-035 SHALL cover same destination: wb1 dest 5 data 0x0001 and wb0 dest 5 data 0x0002 both valid -> commits 0x0001 then 0x0002; register 5 ends at 0x0002.
REQ-036 SHALL cover reset mid-stream: rst pulsed 1 cycle while en = 1 and both valid -> after reset all outputs 0, readies 0 during rst, wb1 granted on the first cycle after.
REQ-037 SHALL cover valid withdrawn: wb0 stalls 3 cycles and then wb0_valid drops for 1 cycle -> starve_cnt returns to 0, and no forced grant occurs until 4 further stalled cycles.
